// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests from the fetch PC and
// buffers {pc, instr} pairs for decode; EX redirects flush and drop in-flight data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]    buf_pc    [DEPTH];
  logic [31:0]    buf_instr [DEPTH];
  logic [DEPTH-1:0] filled;
  logic [AW-1:0]  head;
  logic [AW-1:0]  alloc_ptr;
  logic [AW-1:0]  fill_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  drop_cnt;
  // Allocated entries still waiting for their response; these become drops on redirect.
  logic [CW-1:0]  pending;

  logic req_fire;
  logic rsp_fill;
  logic rsp_drop;
  logic deq;

  // Request/dequeue qualification and head presentation.
  always_comb begin
    imem_req_valid = reset_n & ~redirect_valid &
                     (({1'b0, count} + {1'b0, drop_cnt}) < DEPTH_C);
    imem_req_addr  = pc;
    req_fire       = imem_req_valid & imem_req_ready;
    rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
    rsp_fill       = imem_rsp_valid & (drop_cnt == '0);
    id_valid       = (count != '0) & filled[head] & ~redirect_valid;
    deq            = id_valid & id_ready;
    id_pc          = buf_pc[head];
    id_instr       = buf_instr[head];
  end

  // Control state: PC, pointers, occupancy and drop accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      head      <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      head      <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pending   <= '0;
      filled    <= '0;
      // A response landing this cycle retires one of the outstanding requests.
      drop_cnt  <= drop_cnt + pending - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc        <= pc + 32'd4;
        alloc_ptr <= alloc_ptr + AW'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (rsp_fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + AW'(1);
      end
      if (deq) begin
        filled[head] <= 1'b0;
        head         <= head + AW'(1);
      end
      count   <= count + CW'(req_fire) - CW'(deq);
      pending <= pending + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  // Buffer payload; validity is tracked by filled/count so no reset is needed.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      buf_pc[alloc_ptr] <= pc;
    end
    if (rsp_fill && !redirect_valid) begin
      buf_instr[fill_ptr] <= imem_rsp_data;
    end
  end

endmodule
